// File: rtl/exec_dispatch_ctrl.sv
// In-order uop dispatch controller: buffers decoded uops in a FIFO and issues
// one per cycle, sequenced by class (ALU back-to-back, MEM waits for LSU, BR shadow).
module exec_dispatch_ctrl #(
  parameter int DEPTH     = 4,
  parameter int BR_SHADOW = 2,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [6:0]       enq_instr_type,
  input  logic [2:0]       enq_funct3,
  input  logic [6:0]       enq_funct7,
  input  logic [4:0]       enq_rd,
  input  logic             mem_busy,
  input  logic             mem_done,
  input  logic             flush,
  output logic             uop_valid_out,
  output logic [6:0]       uop_instr_type,
  output logic [2:0]       uop_funct3,
  output logic [6:0]       uop_funct7,
  output logic [4:0]       uop_rd,
  output logic [CNT_W-1:0] occupancy,
  output logic             stall_mem
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SH_W  = $clog2(BR_SHADOW + 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [SH_W-1:0]  SHADOW_INIT = SH_W'(BR_SHADOW);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, BR_WAIT} state_t;

  state_t           state;
  logic [6:0]       fifo_type [DEPTH];
  logic [2:0]       fifo_f3   [DEPTH];
  logic [6:0]       fifo_f7   [DEPTH];
  logic [4:0]       fifo_rd   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [SH_W-1:0]  shadow;
  logic [6:0]       head_type;
  logic             head_mem;
  logic             head_br;
  logic             push;
  logic             issue;

  assign enq_ready = (count < FULL_CNT);
  assign occupancy = count;

  always_comb begin
    head_type = fifo_type[head];
    head_mem  = (head_type == OP_LOAD) || (head_type == OP_STORE);
    head_br   = (head_type == OP_BRANCH) || (head_type == OP_JAL) || (head_type == OP_JALR);
    push      = enq_valid && enq_ready && !flush;
    issue     = !flush && (state == IDLE) && (count != '0) && !(head_mem && mem_busy);
  end

  // Storage array carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_type[tail] <= enq_instr_type;
      fifo_f3[tail]   <= enq_funct3;
      fifo_f7[tail]   <= enq_funct7;
      fifo_rd[tail]   <= enq_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      state          <= IDLE;
      shadow         <= '0;
      uop_valid_out  <= 1'b0;
      uop_instr_type <= '0;
      uop_funct3     <= '0;
      uop_funct7     <= '0;
      uop_rd         <= '0;
      stall_mem      <= 1'b0;
    end else if (flush) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      state         <= IDLE;
      shadow        <= '0;
      uop_valid_out <= 1'b0;
      stall_mem     <= 1'b0;
    end else begin
      if (push)  tail <= tail + PTR_W'(1);
      if (issue) head <= head + PTR_W'(1);
      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      uop_valid_out <= issue;
      if (issue) begin
        uop_instr_type <= head_type;
        uop_funct3     <= fifo_f3[head];
        uop_funct7     <= fifo_f7[head];
        uop_rd         <= fifo_rd[head];
      end
      case (state)
        IDLE: begin
          if (issue && head_mem) begin
            state     <= MEM_WAIT;
            stall_mem <= 1'b1;
          end else if (issue && head_br) begin
            state  <= BR_WAIT;
            shadow <= SHADOW_INIT;
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            state     <= IDLE;
            stall_mem <= 1'b0;
          end
        end
        BR_WAIT: begin
          // Leaving on the count-of-1 edge yields exactly BR_SHADOW bubbles.
          if (shadow == SH_W'(1)) begin
            state  <= IDLE;
            shadow <= '0;
          end else begin
            shadow <= shadow - SH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
